// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters (0: core datapath, 1: aux/debug port) share one
// combinational ALU. Each operation is accepted over valid/ready, the ALU is driven for
// one cycle, and the result, ZF and SF are returned with the requester ID over valid/ready.
// Optional feature macro: ALU_ARB_ILLEGAL_OP_EN. When defined, ALUControl code 3'b011 is
// answered directly with an error response and does not touch the ALU.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // request side
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*WIDTH-1:0] req_srca_i,
    input  logic [2*WIDTH-1:0] req_srcb_i,
    input  logic [5:0]         req_op_i,
    // ALU side
    output logic [WIDTH-1:0]   alu_srca_o,
    output logic [WIDTH-1:0]   alu_srcb_o,
    output logic [2:0]         alu_ctrl_o,
    input  logic [WIDTH-1:0]   alu_result_i,
    input  logic               alu_zf_i,
    input  logic               alu_sf_i,
    // response side
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [WIDTH-1:0]   rsp_result_o,
    output logic               rsp_zf_o,
    output logic               rsp_sf_o,
    output logic               rsp_err_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e             state_q;
    logic               rr_last_q;   // requester served most recently
    logic               gnt_q;       // requester owning the op in flight
    logic [WIDTH-1:0]   alu_srca_q;
    logic [WIDTH-1:0]   alu_srcb_q;
    logic [2:0]         alu_ctrl_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [WIDTH-1:0]   rsp_result_q;
    logic               rsp_zf_q;
    logic               rsp_sf_q;

    logic               gnt_any;
    logic               gnt_id;
    logic [WIDTH-1:0]   sel_srca;
    logic [WIDTH-1:0]   sel_srcb;
    logic [2:0]         sel_op;

    // Grant decision: only offered in IDLE and out of reset; contention alternates.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (rst_ni && (state_q == StIdle)) begin
            case (req_valid_i)
                2'b01: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    gnt_id  = ~rr_last_q;
                end
                default: begin
                    gnt_any = 1'b0;
                    gnt_id  = 1'b0;
                end
            endcase
        end
    end

    // Operand/op mux for the granted requester.
    always_comb begin
        sel_srca = gnt_id ? req_srca_i[2*WIDTH-1:WIDTH] : req_srca_i[WIDTH-1:0];
        sel_srcb = gnt_id ? req_srcb_i[2*WIDTH-1:WIDTH] : req_srcb_i[WIDTH-1:0];
        sel_op   = gnt_id ? req_op_i[5:3] : req_op_i[2:0];
    end

    assign req_ready_o = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic rsp_err_q;
    logic op_illegal;

    assign op_illegal = (sel_op == 3'b011);

    // Operation FSM with registered ALU drive and response; illegal codes bypass EXEC.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            rr_last_q    <= 1'b1;
            gnt_q        <= 1'b0;
            alu_srca_q   <= '0;
            alu_srcb_q   <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zf_q     <= 1'b0;
            rsp_sf_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        gnt_q <= gnt_id;
                        if (op_illegal) begin
                            // ALU registers intentionally left untouched.
                            rsp_valid_q  <= 1'b1;
                            rsp_id_q     <= gnt_id;
                            rsp_result_q <= '0;
                            rsp_zf_q     <= 1'b1;
                            rsp_sf_q     <= 1'b0;
                            rsp_err_q    <= 1'b1;
                            state_q      <= StResp;
                        end else begin
                            alu_srca_q <= sel_srca;
                            alu_srcb_q <= sel_srcb;
                            alu_ctrl_q <= sel_op;
                            state_q    <= StExec;
                        end
                    end
                end
                StExec: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= gnt_q;
                    rsp_result_q <= alu_result_i;
                    rsp_zf_q     <= alu_zf_i;
                    rsp_sf_q     <= alu_sf_i;
                    rsp_err_q    <= 1'b0;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rr_last_q   <= gnt_q;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    // Operation FSM with registered ALU drive and response; every code goes through EXEC.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            rr_last_q    <= 1'b1;
            gnt_q        <= 1'b0;
            alu_srca_q   <= '0;
            alu_srcb_q   <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zf_q     <= 1'b0;
            rsp_sf_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        gnt_q      <= gnt_id;
                        alu_srca_q <= sel_srca;
                        alu_srcb_q <= sel_srcb;
                        alu_ctrl_q <= sel_op;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= gnt_q;
                    rsp_result_q <= alu_result_i;
                    rsp_zf_q     <= alu_zf_i;
                    rsp_sf_q     <= alu_sf_i;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rr_last_q   <= gnt_q;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_err_o = 1'b0;
`endif

    assign alu_srca_o   = alu_srca_q;
    assign alu_srcb_o   = alu_srcb_q;
    assign alu_ctrl_o   = alu_ctrl_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zf_o     = rsp_zf_q;
    assign rsp_sf_o     = rsp_sf_q;
    assign busy_o       = (state_q != StIdle);

endmodule
